case_convert_stream: RTL and testbench

Streaming, parametrised ASCII case converter: accepts `LANES` bytes per beat over a valid/ready handshake. Each enabled byte is converted to upper case, converted to lower case, case-swapped or passed through, according to a per-packet mode. Output is registered with a skid buffer so full throughput is kept under backpressure. The block also reports, per packet, how many characters were actually changed. It replaces the single-byte combinational upper-case gate in the character-processing path.

---
 rtl/case_conv_pkg.sv | 27 ++
 rtl/case_conv_lane.sv | 33 +++
 rtl/case_convert_stream.sv | 192 +++++++++++++++++++
 tb/tb_case_convert_stream.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/case_conv_pkg.sv
// Shared types and constants for the streaming ASCII case converter.
package case_conv_pkg;

  // Per-packet conversion mode, encoded as carried on mode_i.
  typedef enum logic [1:0] {
    MODE_PASS  = 2'd0,
    MODE_UPPER = 2'd1,
    MODE_LOWER = 2'd2,
    MODE_SWAP  = 2'd3
  } mode_e;

  // Packet tracking state: IDLE expects a first beat, IN_PKT a continuation.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } state_e;

  // ASCII letter ranges.
  localparam logic [7:0] ASCII_UPPER_MIN = 8'h41;
  localparam logic [7:0] ASCII_UPPER_MAX = 8'h5A;
  localparam logic [7:0] ASCII_LOWER_MIN = 8'h61;
  localparam logic [7:0] ASCII_LOWER_MAX = 8'h7A;

  // Upper and lower case letters differ only in bit 5.
  localparam logic [7:0] CASE_MASK = 8'h20;

endpackage

// File: rtl/case_conv_lane.sv
// One byte lane of the case converter: purely combinational.
module case_conv_lane
  import case_conv_pkg::*;
(
  input  logic [7:0] data_i,
  input  mode_e      mode_i,
  input  logic       keep_i,
  output logic [7:0] data_o,
  output logic       changed_o
);

  logic is_upper;
  logic is_lower;
  logic flip;

  // Classify the byte, decide whether bit 5 flips, and flag a real change.
  always_comb begin
    is_upper = (data_i >= ASCII_UPPER_MIN) && (data_i <= ASCII_UPPER_MAX);
    is_lower = (data_i >= ASCII_LOWER_MIN) && (data_i <= ASCII_LOWER_MAX);
    flip     = 1'b0;
    if (keep_i) begin
      case (mode_i)
        MODE_UPPER: flip = is_lower;
        MODE_LOWER: flip = is_upper;
        MODE_SWAP:  flip = is_upper | is_lower;
        default:    flip = 1'b0;
      endcase
    end
    data_o    = flip ? (data_i ^ CASE_MASK) : data_i;
    changed_o = (data_o != data_i);
  end

endmodule

// File: rtl/case_convert_stream.sv
// Streaming ASCII case converter with per-packet mode, a 2-entry skid
// buffer on the output and a saturating per-packet changed-character count.
//
// Handshake: a beat moves on a port in a cycle where valid and ready are both
// high. A source holds valid and its payload until that happens; in_ready is a
// flop (skid register empty) so out_ready never reaches it combinationally.
module case_convert_stream
  import case_conv_pkg::*;
#(
  parameter int LANES = 4,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         mode_i,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*LANES-1:0] in_data,
  input  logic [LANES-1:0]   in_keep,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] out_data,
  output logic [LANES-1:0]   out_keep,
  output logic               out_last,
  output logic               stat_valid,
  output logic [CNT_W-1:0]   stat_count,
  output state_e             dbg_state
);

  localparam int POP_W = $clog2(LANES + 1);
  localparam int SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

  // Packet FSM and counter state.
  state_e             state_q, state_d;
  mode_e              mode_q, mode_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               stat_valid_q, stat_valid_d;
  logic [CNT_W-1:0]   stat_count_q, stat_count_d;

  // Output register and skid register.
  logic               out_valid_q, out_valid_d;
  logic [8*LANES-1:0] out_data_q, out_data_d;
  logic [LANES-1:0]   out_keep_q, out_keep_d;
  logic               out_last_q, out_last_d;
  logic               skid_valid_q, skid_valid_d;
  logic [8*LANES-1:0] skid_data_q, skid_data_d;
  logic [LANES-1:0]   skid_keep_q, skid_keep_d;
  logic               skid_last_q, skid_last_d;
  logic               in_ready_q, in_ready_d;

  // Combinational helpers.
  mode_e              cur_mode;
  logic [8*LANES-1:0] conv_data;
  logic [LANES-1:0]   lane_changed;
  logic               accept;
  logic [SUM_W-1:0]   pop;
  logic [SUM_W-1:0]   sum;
  logic [CNT_W-1:0]   sum_sat;

  // The first beat of a packet takes its mode straight from mode_i.
  assign cur_mode = (state_q == ST_IDLE) ? mode_e'(mode_i) : mode_q;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    case_conv_lane u_lane (
      .data_i    (in_data[8*k +: 8]),
      .mode_i    (cur_mode),
      .keep_i    (in_keep[k]),
      .data_o    (conv_data[8*k +: 8]),
      .changed_o (lane_changed[k])
    );
  end

  // in_ready is held low during reset; the flop itself resets to "skid empty".
  assign in_ready = in_ready_q & ~rst;
  assign accept   = in_valid & in_ready;

  // Count changed lanes and add them to the running total with saturation.
  always_comb begin
    pop = '0;
    for (int k = 0; k < LANES; k++) begin
      pop = pop + SUM_W'(lane_changed[k]);
    end
    sum     = {{(SUM_W-CNT_W){1'b0}}, cnt_q} + pop;
    sum_sat = (sum > CNT_MAX) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  end

  // Next-state logic for the FSM, counter and skid buffer.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    cnt_d        = cnt_q;
    stat_valid_d = 1'b0;
    stat_count_d = stat_count_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_keep_d   = out_keep_q;
    out_last_d   = out_last_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_keep_d  = skid_keep_q;
    skid_last_d  = skid_last_q;

    if (accept) begin
      if (state_q == ST_IDLE) begin
        mode_d  = mode_e'(mode_i);
        state_d = in_last ? ST_IDLE : ST_IN_PKT;
      end else if (in_last) begin
        state_d = ST_IDLE;
      end
      if (in_last) begin
        stat_count_d = sum_sat;
        stat_valid_d = 1'b1;
        cnt_d        = '0;
      end else begin
        cnt_d = sum_sat;
      end
    end

    // Output register is free or draining: refill from skid first to keep
    // order, otherwise from the input. A new beat is only accepted while the
    // skid is empty, so the two sources never compete.
    if (!out_valid_q || out_ready) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        out_keep_d   = skid_keep_q;
        out_last_d   = skid_last_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = accept;
        if (accept) begin
          out_data_d = conv_data;
          out_keep_d = in_keep;
          out_last_d = in_last;
        end
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = conv_data;
      skid_keep_d  = in_keep;
      skid_last_d  = in_last;
    end

    in_ready_d = ~skid_valid_d;
  end

  // State registers with synchronous reset; a reset drops all buffered beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      mode_q       <= MODE_PASS;
      cnt_q        <= '0;
      stat_valid_q <= 1'b0;
      stat_count_q <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_keep_q   <= '0;
      out_last_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_keep_q  <= '0;
      skid_last_q  <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      cnt_q        <= cnt_d;
      stat_valid_q <= stat_valid_d;
      stat_count_q <= stat_count_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_keep_q   <= out_keep_d;
      out_last_q   <= out_last_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_keep_q  <= skid_keep_d;
      skid_last_q  <= skid_last_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_keep   = out_keep_q;
  assign out_last   = out_last_q;
  assign stat_valid = stat_valid_q;
  assign stat_count = stat_count_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_case_convert_stream.sv
// Directed bench for case_convert_stream: expected beats and packet counts
// are queued at input acceptance and checked by independent monitors.
module tb_case_convert_stream;
  import case_conv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode_i;
  logic        in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_keep;
  logic        in_last;
  logic        out_ready;

  logic        in_ready, out_valid, out_last, stat_valid;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic [15:0] stat_count;
  state_e      dbg_state;

  logic        s_in_ready, s_out_valid, s_out_last, s_stat_valid;
  logic [31:0] s_out_data;
  logic [3:0]  s_out_keep;
  logic [2:0]  s_stat_count;
  state_e      s_dbg_state;

  case_convert_stream #(.LANES(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .mode_i(mode_i),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_keep(in_keep), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_keep(out_keep), .out_last(out_last),
    .stat_valid(stat_valid), .stat_count(stat_count), .dbg_state(dbg_state)
  );

  // Narrow-counter copy on the same stimulus, used for saturation checks.
  case_convert_stream #(.LANES(4), .CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .mode_i(mode_i),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .in_keep(in_keep), .in_last(in_last),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .out_keep(s_out_keep), .out_last(s_out_last),
    .stat_valid(s_stat_valid), .stat_count(s_stat_count), .dbg_state(s_dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int acc_cnt   = 0;

  logic [36:0] exp_q[$];
  logic [15:0] exp_stat_q[$];
  logic [2:0]  exp_sat_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Drive one beat and wait (bounded) for it to be accepted.
  task automatic send_beat(input logic [1:0] mode, input logic [31:0] data,
                           input logic [3:0] keep, input logic last,
                           input logic [31:0] exp_data, input int exp_count);
    logic ok;
    int   budget;
    mode_i   = mode;
    in_data  = data;
    in_keep  = keep;
    in_last  = last;
    in_valid = 1'b1;
    ok       = 1'b0;
    budget   = 0;
    while (!ok && budget < 100) begin
      ok = in_ready;
      tick();
      budget++;
    end
    in_valid = 1'b0;
    if (!ok) begin
      total_cnt++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, expected 1", budget);
    end else begin
      exp_q.push_back({last, keep, exp_data});
      acc_cnt++;
      if (last) begin
        exp_stat_q.push_back(16'(exp_count));
        exp_sat_q.push_back((exp_count > 7) ? 3'd7 : 3'(exp_count));
      end
    end
  endtask

  // Output beat monitor: order, content and stability under stall.
  logic        stall_prev = 1'b0;
  logic [36:0] held;
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", 64'(out_valid), 64'(1));
        check("hold_beat", 64'({out_last, out_keep, out_data}), 64'(held));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_beat: got %0h, expected none", {out_last, out_keep, out_data});
        end else begin
          check("out_beat", 64'({out_last, out_keep, out_data}), 64'(exp_q.pop_front()));
        end
      end
      stall_prev = out_valid && !out_ready;
      held       = {out_last, out_keep, out_data};
    end
  end

  // Packet count monitors.
  always @(negedge clk) begin
    if (!rst && stat_valid) begin
      if (exp_stat_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_stat: got count %0d, expected no pulse", stat_count);
      end else begin
        check("stat_count", 64'(stat_count), 64'(exp_stat_q.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && s_stat_valid) begin
      if (exp_sat_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_sat_stat: got count %0d, expected no pulse", s_stat_count);
      end else begin
        check("sat_stat_count", 64'(s_stat_count), 64'(exp_sat_q.pop_front()));
      end
    end
  end

  initial begin
    int  base;
    logic seen;
    rst       = 1'b1;
    mode_i    = 2'd0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_keep   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();

    // Reset state.
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_out_keep", 64'(out_keep), 64'(0));
    check("rst_out_last", 64'(out_last), 64'(0));
    check("rst_stat_valid", 64'(stat_valid), 64'(0));
    check("rst_stat_count", 64'(stat_count), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    rst = 1'b0;
    #1;
    check("in_ready_after_release", 64'(in_ready), 64'(1));

    // UPPER single beat 0x61 0x7B 0x5A 0x60: one-cycle latency and stat pulse.
    send_beat(MODE_UPPER, 32'h605A7B61, 4'hF, 1'b1, 32'h605A7B41, 1);
    #1;
    check("latency_valid", 64'(out_valid), 64'(1));
    check("latency_data", 64'(out_data), 64'(32'h605A7B41));
    check("stat_pulse", 64'(stat_valid), 64'(1));
    check("stat_pulse_count", 64'(stat_count), 64'(1));
    tick();
    check("stat_pulse_end", 64'(stat_valid), 64'(0));

    // SWAP two-beat packet; mode_i changed mid-packet is ignored.
    send_beat(MODE_SWAP, 32'h44634261, 4'hF, 1'b0, 32'h64436241, 0);
    check("state_in_pkt", 64'(dbg_state), 64'(ST_IN_PKT));
    send_beat(MODE_PASS, 32'h32314665, 4'hF, 1'b1, 32'h32316645, 6);

    // LOWER with partial keep, high-bit bytes, range boundaries, PASS.
    send_beat(MODE_LOWER, 32'h44434241, 4'b0101, 1'b1, 32'h44634261, 2);
    for (int m = 0; m < 4; m++)
      send_beat(2'(m), 32'hE1C1E1C1, 4'hF, 1'b1, 32'hE1C1E1C1, 0);
    send_beat(MODE_SWAP, 32'h7B605B40, 4'hF, 1'b1, 32'h7B605B40, 0);
    send_beat(MODE_SWAP, 32'h7A615A41, 4'hF, 1'b1, 32'h5A417A61, 4);
    send_beat(MODE_PASS, 32'h44634261, 4'hF, 1'b1, 32'h44634261, 0);
    repeat (3) tick();

    // Six-beat UPPER stream with out_ready low for 5 cycles.
    base = acc_cnt;
    seen = 1'b0;
    fork
      begin
        send_beat(MODE_UPPER, 32'h64636261, 4'hF, 1'b0, 32'h44434241, 0);
        send_beat(MODE_UPPER, 32'h48474645, 4'hF, 1'b0, 32'h48474645, 0);
        send_beat(MODE_UPPER, 32'h21316A69, 4'hF, 1'b0, 32'h21314A49, 0);
        send_beat(MODE_UPPER, 32'h607B5A7A, 4'hF, 1'b0, 32'h607B5A5A, 0);
        send_beat(MODE_UPPER, 32'h706F6E6D, 4'hF, 1'b0, 32'h504F4E4D, 0);
        send_beat(MODE_UPPER, 32'h79787E71, 4'hF, 1'b1, 32'h59587E51, 14);
      end
      begin
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          if (!seen && acc_cnt == base + 2) begin
            check("bp_in_ready_low", 64'(in_ready), 64'(0));
            seen = 1'b1;
          end
        end
        check("bp_two_stored", 64'(seen), 64'(1));
        tick();
        out_ready = 1'b1;
      end
    join
    repeat (4) tick();

    // Saturation on the narrow copy: 12 conversions.
    send_beat(MODE_UPPER, 32'h64636261, 4'hF, 1'b0, 32'h44434241, 0);
    send_beat(MODE_UPPER, 32'h68676665, 4'hF, 1'b0, 32'h48474645, 0);
    send_beat(MODE_UPPER, 32'h6C6B6A69, 4'hF, 1'b1, 32'h4C4B4A49, 12);
    repeat (4) tick();

    // Reset mid-packet with two beats buffered.
    out_ready = 1'b0;
    send_beat(MODE_SWAP, 32'h44634261, 4'hF, 1'b0, 32'h64436241, 0);
    send_beat(MODE_SWAP, 32'h32314665, 4'hF, 1'b0, 32'h32316645, 0);
    check("pre_rst_in_ready", 64'(in_ready), 64'(0));
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("rst_mid_in_ready", 64'(in_ready), 64'(0));
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_out_valid", 64'(out_valid), 64'(0));
    check("post_rst_stat_valid", 64'(stat_valid), 64'(0));
    check("post_rst_stat_count", 64'(stat_count), 64'(0));
    check("post_rst_state", 64'(dbg_state), 64'(ST_IDLE));
    out_ready = 1'b1;
    send_beat(MODE_UPPER, 32'h44634261, 4'hF, 1'b1, 32'h44434241, 2);

    // Drain and confirm nothing is left outstanding.
    for (int i = 0; i < 50; i++) begin
      if (exp_q.size() == 0 && exp_stat_q.size() == 0 && exp_sat_q.size() == 0) break;
      tick();
    end
    repeat (2) tick();
    check("beats_outstanding", 64'(exp_q.size()), 64'(0));
    check("stats_outstanding", 64'(exp_stat_q.size()), 64'(0));
    check("sat_stats_outstanding", 64'(exp_sat_q.size()), 64'(0));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
